// File: rtl/accumulator_bank_pkg.sv
// accumulator_bank_pkg: shared constants, lane-slice helper and drain FSM state type
package accumulator_bank_pkg;
  localparam int ACC_LANES  = 32;
  localparam int ACC_DATA_W = 32;
  localparam int ACC_ADDR_W = 7;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} drain_state_t;
  function automatic logic [ACC_DATA_W-1:0] lane_slice(input logic [ACC_LANES*ACC_DATA_W-1:0] row, input int unsigned l);
    return row[l*ACC_DATA_W +: ACC_DATA_W];
  endfunction
endpackage

// File: rtl/accumulator_bank_lane_update.sv
// accum_lane_update: one lane of the masked add/overwrite datapath
module accum_lane_update #(
  parameter int DATA_W = 32
) (
  input  logic              en_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] psum_i,
  output logic [DATA_W-1:0] new_o
);
  assign new_o = en_i ? (add_i ? old_i + psum_i : psum_i) : old_i;
endmodule

// File: rtl/accumulator_bank.sv
// accumulator_bank: masked accumulate row storage with registered read port and drain engine
module accumulator_bank
  import accumulator_bank_pkg::*;
#(
  parameter int LANES  = ACC_LANES,
  parameter int DATA_W = ACC_DATA_W,
  parameter int ADDR_W = ACC_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    write_accumulator_i,
  input  logic                    accumulator_add_i,
  input  logic [ADDR_W-1:0]       accumulator_addr_wr_i,
  input  logic [LANES-1:0]        accum_addr_mask_i,
  input  logic [LANES*DATA_W-1:0] psum_i,
  input  logic                    read_accumulator_i,
  input  logic [ADDR_W-1:0]       accumulator_addr_rd_i,
  output logic [LANES*DATA_W-1:0] rd_data_o,
  output logic                    rd_valid_o,
  input  logic                    drain_start_i,
  input  logic [ADDR_W-1:0]       drain_base_i,
  input  logic [ADDR_W:0]         drain_rows_i,
  output logic [LANES*DATA_W-1:0] drain_data_o,
  output logic [ADDR_W-1:0]       drain_addr_o,
  output logic                    drain_valid_o,
  input  logic                    drain_ready_i,
  output logic                    drain_busy_o,
  output logic                    drain_done_o
);
  logic [LANES*DATA_W-1:0] mem_q [DEPTH];
  logic [LANES*DATA_W-1:0] old_row, row_d, rd_row, drain_row;
  logic [LANES*DATA_W-1:0] rd_data_q, drain_data_q;
  logic [ADDR_W-1:0]       ptr_q, ptr_d, drain_addr_q;
  logic [ADDR_W:0]         cnt_q;
  logic                    rd_valid_q, drain_valid_q, drain_done_q;
  drain_state_t            state_q;
  assign old_row = mem_q[accumulator_addr_wr_i];
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    accum_lane_update #(.DATA_W(DATA_W)) u_lane (
      .en_i   (accum_addr_mask_i[LANES-1-l]),
      .add_i  (accumulator_add_i),
      .old_i  (lane_slice(old_row, l)),
      .psum_i (lane_slice(psum_i, l)),
      .new_o  (row_d[l*DATA_W +: DATA_W])
    );
  end
  // Reads that collide with a same-cycle write see the merged post-write row
  assign ptr_d     = (state_q == HOLD) ? ptr_q + 1'b1 : ptr_q;
  assign rd_row    = (write_accumulator_i && accumulator_addr_rd_i == accumulator_addr_wr_i) ? row_d : mem_q[accumulator_addr_rd_i];
  assign drain_row = (write_accumulator_i && ptr_d == accumulator_addr_wr_i) ? row_d : mem_q[ptr_d];
  always_ff @(posedge clk_i)
    if (write_accumulator_i) mem_q[accumulator_addr_wr_i] <= row_d;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= read_accumulator_i;
      if (read_accumulator_i) rd_data_q <= rd_row;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      drain_data_q  <= '0;
      drain_addr_q  <= '0;
      drain_valid_q <= 1'b0;
      drain_done_q  <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      case (state_q)
        IDLE: if (drain_start_i && drain_rows_i != '0) begin
          ptr_q   <= drain_base_i;
          cnt_q   <= drain_rows_i;
          state_q <= FETCH;
        end
        FETCH: begin
          drain_data_q  <= drain_row;
          drain_addr_q  <= ptr_d;
          drain_valid_q <= 1'b1;
          state_q       <= HOLD;
        end
        HOLD: if (drain_ready_i) begin
          if (cnt_q == 1) begin
            drain_valid_q <= 1'b0;
            drain_done_q  <= 1'b1;
            state_q       <= IDLE;
          end else begin
            drain_data_q <= drain_row;
            drain_addr_q <= ptr_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;
  assign drain_data_o  = drain_data_q;
  assign drain_addr_o  = drain_addr_q;
  assign drain_valid_o = drain_valid_q;
  assign drain_done_o  = drain_done_q;
  assign drain_busy_o  = state_q != IDLE;
endmodule

// File: tb/tb_accumulator_bank.sv
// tb_accumulator_bank: directed self-checking bench for accumulator_bank
module tb_accumulator_bank;
  localparam int L = 32, W = 32, A = 7;
  logic clk = 1'b0, rst_i = 1'b0;
  logic wr = 1'b0, add = 1'b0, rd = 1'b0, start = 1'b0, ready = 1'b0;
  logic [A-1:0] waddr = '0, raddr = '0, base = '0, daddr;
  logic [A:0] rows = '0;
  logic [L-1:0] mask = '0;
  logic [L*W-1:0] psum = '0, rdata, ddata, exp_row;
  logic rvalid, dvalid, busy, done;
  int vectors = 0, errs = 0;
  always #5 clk = ~clk;
  accumulator_bank dut (
    .clk_i(clk), .rst_i(rst_i), .write_accumulator_i(wr), .accumulator_add_i(add),
    .accumulator_addr_wr_i(waddr), .accum_addr_mask_i(mask), .psum_i(psum),
    .read_accumulator_i(rd), .accumulator_addr_rd_i(raddr), .rd_data_o(rdata), .rd_valid_o(rvalid),
    .drain_start_i(start), .drain_base_i(base), .drain_rows_i(rows), .drain_data_o(ddata),
    .drain_addr_o(daddr), .drain_valid_o(dvalid), .drain_ready_i(ready), .drain_busy_o(busy),
    .drain_done_o(done)
  );
  function automatic logic [L*W-1:0] rowv(input int v);
    return {L{32'(v)}};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_row(input string tag, input logic [L*W-1:0] obs, input logic [L*W-1:0] exp);
    int bad;
    bad = 0;
    for (int i = L - 1; i >= 0; i--) if (obs[i*W +: W] !== exp[i*W +: W]) bad = i;
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s lane%0d observed=%h expected=%h", tag, bad, obs[bad*W +: W], exp[bad*W +: W]);
    end
  endtask
  task automatic write(input int a, input logic ad, input logic [L-1:0] m, input int v);
    wr = 1'b1; waddr = A'(a); add = ad; mask = m; psum = rowv(v);
    tick();
    wr = 1'b0;
  endtask
  task automatic chk_drain(input string tag, input logic v, input int a, input logic dn, input logic bz);
    chk({tag, "_valid"}, 32'(dvalid), 32'(v));
    if (v) chk({tag, "_addr"}, 32'(daddr), 32'(a));
    chk({tag, "_done"}, 32'(done), 32'(dn));
    chk({tag, "_busy"}, 32'(busy), 32'(bz));
  endtask
  initial begin
    tick();
    tick();
    chk("rst_rvalid", 32'(rvalid), 0);
    chk_row("rst_rdata", rdata, '0);
    chk_row("rst_ddata", ddata, '0);
    chk_drain("rst", 1'b0, 0, 1'b0, 1'b0);
    rst_i = 1'b1;
    // overwrite then accumulate
    write(5, 1'b0, '1, 3);
    write(5, 1'b1, '1, 4);
    rd = 1'b1; raddr = 5;
    tick();
    rd = 1'b0;
    chk("rd5_valid", 32'(rvalid), 1);
    chk_row("rd5_data", rdata, rowv(7));
    tick();
    chk("rd_idle_valid", 32'(rvalid), 0);
    chk_row("rd_hold_data", rdata, rowv(7));
    // partial mask, MSB of mask is lane 0
    write(10, 1'b0, '1, 1);
    write(10, 1'b1, 32'h8000_0000, 9);
    rd = 1'b1; raddr = 10;
    tick();
    exp_row = rowv(1); exp_row[W-1:0] = 32'd10;
    chk_row("mask_lane0", rdata, exp_row);
    wr = 1'b1; waddr = 10; add = 1'b1; mask = 32'h7FFF_FFFF; psum = rowv(1);
    tick();
    exp_row = rowv(2); exp_row[W-1:0] = 32'd10;
    chk_row("mask_rest_fwd", rdata, exp_row);
    mask = '0; psum = rowv(55);
    tick();
    chk_row("mask_zero_noop", rdata, exp_row);
    wr = 1'b0; rd = 1'b0;
    // wrap modulo 2**32 with same-cycle read of the written row
    write(0, 1'b0, '1, 32'hFFFF_FFFF);
    wr = 1'b1; waddr = 0; add = 1'b1; mask = '1; psum = rowv(2); rd = 1'b1; raddr = 0;
    tick();
    wr = 1'b0; rd = 1'b0;
    chk_row("wrap_fwd", rdata, rowv(1));
    // drain with backpressure across the address wrap
    write(126, 1'b0, '1, 32'h1000 + 126);
    write(127, 1'b0, '1, 32'h1000 + 127);
    write(0, 1'b0, '1, 32'h1000);
    write(1, 1'b0, '1, 32'h1001);
    start = 1'b1; base = 126; rows = 0;
    tick();
    chk_drain("zero_rows", 1'b0, 0, 1'b0, 1'b0);
    rows = 4;
    tick();
    start = 1'b0;
    chk_drain("d_fetch", 1'b0, 0, 1'b0, 1'b1);
    tick();
    chk_drain("d0", 1'b1, 126, 1'b0, 1'b1);
    chk_row("d0_data", ddata, rowv(32'h1000 + 126));
    ready = 1'b1;
    tick();
    chk_drain("d1", 1'b1, 127, 1'b0, 1'b1);
    chk_row("d1_data", ddata, rowv(32'h1000 + 127));
    ready = 1'b0; start = 1'b1; base = 40; rows = 1;
    tick();
    start = 1'b0;
    chk_drain("d1_stall_a", 1'b1, 127, 1'b0, 1'b1);
    tick();
    chk_drain("d1_stall_b", 1'b1, 127, 1'b0, 1'b1);
    chk_row("d1_stall_data", ddata, rowv(32'h1000 + 127));
    ready = 1'b1;
    tick();
    chk_drain("d2", 1'b1, 0, 1'b0, 1'b1);
    chk_row("d2_data", ddata, rowv(32'h1000));
    tick();
    chk_drain("d3", 1'b1, 1, 1'b0, 1'b1);
    chk_row("d3_data", ddata, rowv(32'h1001));
    tick();
    chk_drain("d_end", 1'b0, 0, 1'b1, 1'b0);
    ready = 1'b0;
    tick();
    chk_drain("d_after", 1'b0, 0, 1'b0, 1'b0);
    // write into a row already held on the drain output
    write(2, 1'b0, '1, 32'h2000);
    write(3, 1'b0, '1, 32'h3000);
    start = 1'b1; base = 2; rows = 2;
    tick();
    start = 1'b0;
    tick();
    chk_drain("c0", 1'b1, 2, 1'b0, 1'b1);
    write(2, 1'b0, '1, 32'hAAAA);
    chk_drain("c0_held", 1'b1, 2, 1'b0, 1'b1);
    chk_row("c0_held_data", ddata, rowv(32'h2000));
    ready = 1'b1;
    tick();
    chk_drain("c1", 1'b1, 3, 1'b0, 1'b1);
    chk_row("c1_data", ddata, rowv(32'h3000));
    tick();
    ready = 1'b0;
    chk_drain("c_end", 1'b0, 0, 1'b1, 1'b0);
    rd = 1'b1; raddr = 2;
    tick();
    rd = 1'b0;
    chk_row("c_rd2", rdata, rowv(32'hAAAA));
    // reset in the middle of a drain, then restart
    start = 1'b1; base = 5; rows = 3;
    tick();
    start = 1'b0;
    tick();
    chk_drain("r_hold", 1'b1, 5, 1'b0, 1'b1);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    chk_drain("r_reset", 1'b0, 0, 1'b0, 1'b0);
    start = 1'b1; base = 10; rows = 1; ready = 1'b1;
    tick();
    start = 1'b0;
    chk_drain("r_fetch", 1'b0, 0, 1'b0, 1'b1);
    tick();
    chk_drain("r_row", 1'b1, 10, 1'b0, 1'b1);
    exp_row = rowv(2); exp_row[W-1:0] = 32'd10;
    chk_row("r_row_data", ddata, exp_row);
    tick();
    chk_drain("r_done", 1'b0, 0, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
